// File: rtl/ysyx_23060025_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060025_rd_arbiter
// Two-master (IFU, LSU) to one-slave AXI-lite read-channel arbiter.
// Only one read is outstanding at a time. The AR and R phases are routed to
// the granted master only. Arbitration takes one IDLE cycle, and a request is
// never passed through in the same cycle it arrives.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   undefined : fixed priority, LSU wins simultaneous requests.
//   defined   : the master not served last wins simultaneous requests.
//               The last-served bit resets to IFU and is updated on R
//               completion.
//
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   ifu_ar_* / ifu_r_*           IFU read address / data channels
//   lsu_ar_* / lsu_r_*           LSU read address / data channels
//   s_ar_* / s_r_*               shared slave read address / data channels
// ---------------------------------------------------------------------------
module ysyx_23060025_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU
  input  logic [ADDR_WIDTH-1:0] ifu_ar_addr_i,
  input  logic                  ifu_ar_valid_i,
  output logic                  ifu_ar_ready_o,
  output logic [DATA_WIDTH-1:0] ifu_r_data_o,
  output logic [1:0]            ifu_r_resp_o,
  output logic                  ifu_r_valid_o,
  input  logic                  ifu_r_ready_i,
  // LSU
  input  logic [ADDR_WIDTH-1:0] lsu_ar_addr_i,
  input  logic                  lsu_ar_valid_i,
  output logic                  lsu_ar_ready_o,
  output logic [DATA_WIDTH-1:0] lsu_r_data_o,
  output logic [1:0]            lsu_r_resp_o,
  output logic                  lsu_r_valid_o,
  input  logic                  lsu_r_ready_i,
  // Slave
  output logic [ADDR_WIDTH-1:0] s_ar_addr_o,
  output logic                  s_ar_valid_o,
  input  logic                  s_ar_ready_i,
  input  logic [DATA_WIDTH-1:0] s_r_data_i,
  input  logic [1:0]            s_r_resp_i,
  input  logic                  s_r_valid_i,
  output logic                  s_r_ready_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IFU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_t;

  state_t state_q, state_d;
  grant_t grant_q, grant_d;
  logic   pick_lsu;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = LSU was served last, 0 = IFU was served last
  logic last_lsu_q, last_lsu_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end

  // On a tie, LSU wins only if IFU was served last
  assign pick_lsu = lsu_ar_valid_i && (!ifu_ar_valid_i || !last_lsu_q);
`else
  assign pick_lsu = lsu_ar_valid_i;
`endif

  // State and grant registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= GNT_NONE;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state and channel routing
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    ifu_ar_ready_o = 1'b0;
    ifu_r_data_o   = '0;
    ifu_r_resp_o   = 2'b00;
    ifu_r_valid_o  = 1'b0;
    lsu_ar_ready_o = 1'b0;
    lsu_r_data_o   = '0;
    lsu_r_resp_o   = 2'b00;
    lsu_r_valid_o  = 1'b0;
    s_ar_addr_o    = '0;
    s_ar_valid_o   = 1'b0;
    s_r_ready_o    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_lsu_d     = last_lsu_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_lsu) begin
          grant_d = GNT_LSU;
          state_d = ADDR;
        end else if (ifu_ar_valid_i) begin
          grant_d = GNT_IFU;
          state_d = ADDR;
        end
      end

      ADDR: begin
        // The grant is held until the handshake, even if valid drops
        if (grant_q == GNT_LSU) begin
          s_ar_addr_o    = lsu_ar_addr_i;
          s_ar_valid_o   = lsu_ar_valid_i;
          lsu_ar_ready_o = s_ar_ready_i;
        end else if (grant_q == GNT_IFU) begin
          s_ar_addr_o    = ifu_ar_addr_i;
          s_ar_valid_o   = ifu_ar_valid_i;
          ifu_ar_ready_o = s_ar_ready_i;
        end
        if (s_ar_valid_o && s_ar_ready_i) begin
          state_d = DATA;
        end
      end

      DATA: begin
        if (grant_q == GNT_LSU) begin
          lsu_r_data_o  = s_r_data_i;
          lsu_r_resp_o  = s_r_resp_i;
          lsu_r_valid_o = s_r_valid_i;
          s_r_ready_o   = lsu_r_ready_i;
        end else if (grant_q == GNT_IFU) begin
          ifu_r_data_o  = s_r_data_i;
          ifu_r_resp_o  = s_r_resp_i;
          ifu_r_valid_o = s_r_valid_i;
          s_r_ready_o   = ifu_r_ready_i;
        end
        // Any response code closes the transaction; there are no retries
        if (s_r_valid_i && s_r_ready_o) begin
`ifdef ARB_ROUND_ROBIN_EN
          last_lsu_d = (grant_q == GNT_LSU);
`endif
          state_d = IDLE;
          grant_d = GNT_NONE;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060025_rd_arbiter
// Scoreboard bench for the read arbiter. Stimulus pushes the expected AR
// entries ({is_lsu, addr}) and R entries ({is_lsu, resp, data}) into queues.
// A negedge monitor compares these entries whenever the DUT presents AR or R
// traffic. A small slave model returns directed data words.
// ---------------------------------------------------------------------------
module tb_ysyx_23060025_rd_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clock, reset;
  logic [AW-1:0] ifu_ar_addr;
  logic          ifu_ar_valid, ifu_ar_ready;
  logic [DW-1:0] ifu_r_data;
  logic [1:0]    ifu_r_resp;
  logic          ifu_r_valid, ifu_r_ready;
  logic [AW-1:0] lsu_ar_addr;
  logic          lsu_ar_valid, lsu_ar_ready;
  logic [DW-1:0] lsu_r_data;
  logic [1:0]    lsu_r_resp;
  logic          lsu_r_valid, lsu_r_ready;
  logic [AW-1:0] s_ar_addr;
  logic          s_ar_valid, s_ar_ready;
  logic [DW-1:0] s_r_data;
  logic [1:0]    s_r_resp;
  logic          s_r_valid, s_r_ready;

  int checks = 0;
  int errors = 0;
  int ar_wait = 0;
  logic stray = 1'b0;

  logic [32:0] arq[$];
  logic [34:0] rq[$];
  logic [32:0] ea;
  logic [34:0] er;

  ysyx_23060025_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .ifu_ar_addr_i (ifu_ar_addr),
    .ifu_ar_valid_i(ifu_ar_valid),
    .ifu_ar_ready_o(ifu_ar_ready),
    .ifu_r_data_o  (ifu_r_data),
    .ifu_r_resp_o  (ifu_r_resp),
    .ifu_r_valid_o (ifu_r_valid),
    .ifu_r_ready_i (ifu_r_ready),
    .lsu_ar_addr_i (lsu_ar_addr),
    .lsu_ar_valid_i(lsu_ar_valid),
    .lsu_ar_ready_o(lsu_ar_ready),
    .lsu_r_data_o  (lsu_r_data),
    .lsu_r_resp_o  (lsu_r_resp),
    .lsu_r_valid_o (lsu_r_valid),
    .lsu_r_ready_i (lsu_r_ready),
    .s_ar_addr_o   (s_ar_addr),
    .s_ar_valid_o  (s_ar_valid),
    .s_ar_ready_i  (s_ar_ready),
    .s_r_data_i    (s_r_data),
    .s_r_resp_i    (s_r_resp),
    .s_r_valid_i   (s_r_valid),
    .s_r_ready_o   (s_r_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s @%0t", name, $time);
  endtask

  // Directed slave memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_word = 32'h0000_0413;
      32'h8000_0004: mem_word = 32'h00A0_0093;
      32'h8000_0008: mem_word = 32'h1234_5678;
      32'h8000_1000: mem_word = 32'hDEAD_BEEF;
      default:       mem_word = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Slave model: samples at negedge, drives just after posedge
  initial begin : slave
    logic ar_vis, ar_hs, r_hs;
    logic [31:0] a;
    int cnt;
    int st;
    s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
    cnt = 0; st = 0;
    forever begin
      @(negedge clock);
      ar_vis = s_ar_valid;
      ar_hs  = s_ar_valid && s_ar_ready;
      r_hs   = s_r_valid && s_r_ready;
      a      = s_ar_addr;
      @(posedge clock); #1;
      if (!reset) begin
        st = 0; cnt = 0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
      end else if (st == 0) begin
        if (ar_hs) begin
          st = 1; cnt = 0;
          s_ar_ready = 1'b0;
          s_r_data   = mem_word(a);
          s_r_resp   = (a == 32'h8000_0008) ? 2'b10 : 2'b00;
          s_r_valid  = 1'b1;
        end else if (ar_vis) begin
          cnt++;
          s_ar_ready = (cnt >= ar_wait);
          s_r_valid  = stray;
        end else begin
          cnt = 0;
          s_ar_ready = (ar_wait == 0);
          s_r_valid  = stray;
        end
      end else if (r_hs) begin
        st = 0;
        s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
        s_ar_ready = (ar_wait == 0);
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset) begin
      if (s_ar_valid) begin
        if (arq.size() == 0) bad("ar_unexpected");
        else begin
          ea = arq[0];
          chk("ar_addr", 64'(s_ar_addr), 64'(ea[31:0]));
          if (s_ar_ready) begin
            chk("ar_grant", 64'({lsu_ar_ready, ifu_ar_ready}), ea[32] ? 64'd2 : 64'd1);
            void'(arq.pop_front());
          end
        end
      end
      if (ifu_r_valid || lsu_r_valid) begin
        if (rq.size() == 0) bad("r_unexpected");
        else begin
          er = rq[0];
          chk("r_owner", 64'({lsu_r_valid, ifu_r_valid}), er[34] ? 64'd2 : 64'd1);
          chk("r_data", 64'(er[34] ? lsu_r_data : ifu_r_data), 64'(er[31:0]));
          chk("r_resp", 64'(er[34] ? lsu_r_resp : ifu_r_resp), 64'(er[33:32]));
          chk("r_other_quiet", 64'(er[34] ? {ifu_r_resp, ifu_r_data} : {lsu_r_resp, lsu_r_data}), 64'd0);
          chk("r_ready_fwd", 64'(s_r_ready), 64'(er[34] ? lsu_r_ready : ifu_r_ready));
          if (s_r_ready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic exp_ar(input logic lsu, input logic [31:0] a);
    arq.push_back({lsu, a});
  endtask

  task automatic exp_r(input logic lsu, input logic [1:0] resp, input logic [31:0] d);
    rq.push_back({lsu, resp, d});
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_ctrl"}, 64'({ifu_ar_ready, ifu_r_valid, lsu_ar_ready, lsu_r_valid, s_ar_valid, s_r_ready}), 64'd0);
    chk({name, "_ifu_r"}, 64'({ifu_r_resp, ifu_r_data}), 64'd0);
    chk({name, "_lsu_r"}, 64'({lsu_r_resp, lsu_r_data}), 64'd0);
    chk({name, "_s_addr"}, 64'(s_ar_addr), 64'd0);
  endtask

  task automatic ifu_read(input logic [31:0] a);
    int n;
    n = 0;
    ifu_ar_addr = a; ifu_ar_valid = 1'b1;
    do begin @(negedge clock); n++; end while (!ifu_ar_ready && n < 100);
    if (!ifu_ar_ready) bad("ifu_ar_timeout");
    @(posedge clock); #1;
    ifu_ar_valid = 1'b0; ifu_ar_addr = '0;
  endtask

  task automatic lsu_read(input logic [31:0] a);
    int n;
    n = 0;
    lsu_ar_addr = a; lsu_ar_valid = 1'b1;
    do begin @(negedge clock); n++; end while (!lsu_ar_ready && n < 100);
    if (!lsu_ar_ready) bad("lsu_ar_timeout");
    @(posedge clock); #1;
    lsu_ar_valid = 1'b0; lsu_ar_addr = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((arq.size() != 0 || rq.size() != 0) && n < 200) begin
      @(negedge clock); n++;
    end
    if (arq.size() != 0 || rq.size() != 0) bad("drain_timeout");
    @(posedge clock); #1;
  endtask

  initial begin : stim
    reset = 1'b0;
    ifu_ar_addr = '0; ifu_ar_valid = 1'b0; ifu_r_ready = 1'b1;
    lsu_ar_addr = '0; lsu_ar_valid = 1'b0; lsu_r_ready = 1'b1;
    #3;
    chk_quiet("reset");
    #10 reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end

    // IFU-only read with cycle-exact timing
    exp_ar(1'b0, 32'h8000_0000);
    exp_r(1'b0, 2'b00, 32'h0000_0413);
    ifu_ar_addr = 32'h8000_0000; ifu_ar_valid = 1'b1;
    @(negedge clock); chk("c1_ifu_ar_ready", 64'(ifu_ar_ready), 64'd0);
    @(negedge clock); chk("c2_ifu_ar_ready", 64'(ifu_ar_ready), 64'd1);
    @(posedge clock); #1; ifu_ar_valid = 1'b0; ifu_ar_addr = '0;
    @(negedge clock);
    chk("c3_ifu_r_valid", 64'(ifu_r_valid), 64'd1);
    chk("c3_ifu_r_data", 64'(ifu_r_data), 64'h0000_0413);
    chk("c3_lsu_quiet", 64'({lsu_ar_ready, lsu_r_valid, lsu_r_data}), 64'd0);
    @(negedge clock);
    chk("c4_idle", 64'({ifu_r_valid, s_ar_valid, s_r_ready}), 64'd0);
    drain();

    // LSU-only read
    exp_ar(1'b1, 32'h8000_0004);
    exp_r(1'b1, 2'b00, 32'h00A0_0093);
    lsu_read(32'h8000_0004);
    drain();

    // Simultaneous request: LSU first, then IFU
    exp_ar(1'b1, 32'h8000_1000);
    exp_r(1'b1, 2'b00, 32'hDEAD_BEEF);
    exp_ar(1'b0, 32'h8000_0004);
    exp_r(1'b0, 2'b00, 32'h00A0_0093);
    fork
      ifu_read(32'h8000_0004);
      lsu_read(32'h8000_1000);
    join
    drain();

    // Backpressure on AR (slave) and R (LSU)
    ar_wait = 5;
    lsu_r_ready = 1'b0;
    repeat (2) begin @(posedge clock); #1; end
    exp_ar(1'b1, 32'h8000_1000);
    exp_r(1'b1, 2'b00, 32'hDEAD_BEEF);
    lsu_read(32'h8000_1000);
    repeat (3) begin @(posedge clock); #1; end
    chk("bp_r_held", 64'(lsu_r_valid), 64'd1);
    lsu_r_ready = 1'b1;
    drain();
    ar_wait = 0;
    repeat (2) begin @(posedge clock); #1; end

    // Error response reaches IFU, then a normal LSU read
    exp_ar(1'b0, 32'h8000_0008);
    exp_r(1'b0, 2'b10, 32'h1234_5678);
    ifu_read(32'h8000_0008);
    drain();
    exp_ar(1'b1, 32'h8000_0000);
    exp_r(1'b1, 2'b00, 32'h0000_0413);
    lsu_read(32'h8000_0000);
    drain();

    // Stray slave r_valid in IDLE
    stray = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    @(negedge clock);
    chk("stray_s_r_ready", 64'(s_r_ready), 64'd0);
    chk("stray_r_valid", 64'({ifu_r_valid, lsu_r_valid}), 64'd0);
    stray = 1'b0;
    repeat (2) begin @(posedge clock); #1; end

    // Async reset during DATA, then a clean IFU read
    ifu_r_ready = 1'b0;
    exp_ar(1'b0, 32'h8000_0000);
    exp_r(1'b0, 2'b00, 32'h0000_0413);
    ifu_read(32'h8000_0000);
    @(posedge clock); #3;
    chk("pre_reset_r_valid", 64'(ifu_r_valid), 64'd1);
    reset = 1'b0;
    #1;
    chk_quiet("async_reset");
    arq.delete();
    rq.delete();
    ifu_r_ready = 1'b1;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    exp_ar(1'b0, 32'h8000_0004);
    exp_r(1'b0, 2'b00, 32'h00A0_0093);
    ifu_read(32'h8000_0004);
    drain();

    chk("end_arq_empty", 64'(arq.size()), 64'd0);
    chk("end_rq_empty", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_23060025_rd_arbiter.md
Name: ysyx_23060025_rd_arbiter

Overview:
- Two-master, one-slave read-channel arbiter.
- Shares the single AXI-lite read port of the memory/SRAM slave between the IFU (instruction fetch) and the LSU (load).
- Sits between both units and the slave; write channels bypass it.
- Serialises transactions: one outstanding read at a time, address and data phases routed to the granted master only.

Parameters:
- ADDR_WIDTH, 32, read address width.
- DATA_WIDTH, 32, read data width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- ifu_ar_addr_i  in  ADDR_WIDTH  IFU read address
- ifu_ar_valid_i  in  1  IFU address valid
- ifu_ar_ready_o  out  1  IFU address accepted
- ifu_r_data_o  out  DATA_WIDTH  IFU read data
- ifu_r_resp_o  out  2  IFU read response
- ifu_r_valid_o  out  1  IFU data valid
- ifu_r_ready_i  in  1  IFU data ready
- lsu_ar_addr_i  in  ADDR_WIDTH  LSU read address
- lsu_ar_valid_i  in  1  LSU address valid
- lsu_ar_ready_o  out  1  LSU address accepted
- lsu_r_data_o  out  DATA_WIDTH  LSU read data
- lsu_r_resp_o  out  2  LSU read response
- lsu_r_valid_o  out  1  LSU data valid
- lsu_r_ready_i  in  1  LSU data ready
- s_ar_addr_o  out  ADDR_WIDTH  slave read address
- s_ar_valid_o  out  1  slave address valid
- s_ar_ready_i  in  1  slave address ready
- s_r_data_i  in  DATA_WIDTH  slave read data
- s_r_resp_i  in  2  slave read response
- s_r_valid_i  in  1  slave data valid
- s_r_ready_o  out  1  slave data ready

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, grant register=NONE.
  - All valid/ready outputs 0; s_ar_addr_o and both r_data/r_resp outputs 0.
- States: IDLE, ADDR, DATA (registered); grant register {NONE, IFU, LSU}.
- IDLE:
  - Outputs all 0.
  - lsu_ar_valid_i=1 -> grant=LSU, next ADDR.
  - Else ifu_ar_valid_i=1 -> grant=IFU, next ADDR.
  - Else stay IDLE.
  - Both requesting: LSU wins (fixed priority).
  - Arbitration costs exactly one bubble cycle; no same-cycle pass-through.
- ADDR:
  - s_ar_addr_o / s_ar_valid_o = granted master's addr/valid.
  - Granted master's ar_ready = s_ar_ready_i; the other master's ar_ready=0.
  - On s_ar_valid_o & s_ar_ready_i -> DATA.
  - Grant held until the handshake, even if the granted master drops valid (protocol violation; no re-arbitration).
- DATA:
  - Granted master's r_data/r_resp/r_valid = slave's; s_r_ready_o = granted master's r_ready.
  - Non-granted master sees r_valid=0, r_data=0, r_resp=0.
  - On s_r_valid_i & s_r_ready_o -> IDLE, grant=NONE.
  - Non-zero r_resp is forwarded unchanged and still completes the transaction.
  - Arbiter never retries.
- Stray s_r_valid_i outside DATA is ignored (s_r_ready_o=0).
- Requests arriving in ADDR/DATA wait; the loser of a simultaneous request is served next, with ar_ready=0 meanwhile.
- Reset mid-transaction: immediate return to IDLE, outputs forced 0; the slave is expected to be reset by the same signal.
- Minimum transaction with a zero-wait slave: 3 cycles (IDLE, ADDR, DATA).

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Adds a 1-bit last-served register (reset=IFU).
  - On simultaneous requests in IDLE, the master not served last wins.
  - Single requests are granted as usual.
  - last-served updates on R-handshake completion.
- Undefined: fixed LSU priority as above; no extra register.

Test Plan:
- IFU-only read: ifu_ar_valid=1, addr=0x8000_0000, slave ready immediately, returns data=0x0000_0413 resp=0 -> ifu_ar_ready pulses in cycle 2, ifu_r_valid=1 with 0x0000_0413 in cycle 3, lsu_* outputs stay 0, state back to IDLE in cycle 4.
- Simultaneous request: IFU addr 0x8000_0004, LSU addr 0x8000_1000 in the same cycle -> s_ar_addr_o=0x8000_1000 first; IFU granted after LSU's R handshake (round-robin build: LSU first, then IFU; a second simultaneous pair goes IFU first).
- Backpressure: slave s_ar_ready low for 5 cycles, then s_r_valid held while lsu_r_ready low for 3 cycles -> grant, address and data stable throughout; exactly one handshake on each channel.
- Error response: slave returns resp=2'b10 to IFU -> ifu_r_resp_o=2'b10 with ifu_r_valid=1, transaction closes, next request arbitrated normally.
- Async reset asserted during DATA (s_r_valid=1) -> all outputs 0 without a clock edge; after release, a new IFU read completes correctly.
- Stray s_r_valid_i=1 in IDLE -> s_r_ready_o=0, no master sees r_valid.
